// File: rtl/axi4_w_buffer_drop.sv
// AXI4 write-data buffer with per-burst forward/drop control.
// Beats from the slave W port are queued in a DEPTH-entry FIFO. For each
// burst, the output side runs one command: forward the burst to the master
// W port, or discard it without ever raising m_axi4_wvalid.
module axi4_w_buffer_drop #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_USER_WIDTH = 2,
  parameter int DEPTH          = 4,
  localparam int CNT_W         = $clog2(DEPTH+1)
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,
  // slave-side W
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                        s_axi4_wlast,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
  input  logic                        s_axi4_wvalid,
  output logic                        s_axi4_wready,
  // master-side W
  output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic                        m_axi4_wlast,
  output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
  output logic                        m_axi4_wvalid,
  input  logic                        m_axi4_wready,
  // per-burst command
  input  logic                        cmd_valid,
  input  logic                        cmd_drop,
  output logic                        cmd_ready,
  output logic                        drop_done,
  // status
  output logic [CNT_W-1:0]            fill_level,
  output logic [CNT_W-1:0]            bursts_stored
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int STRB_W = AXI_DATA_WIDTH/8;

  typedef struct packed {
    logic [AXI_USER_WIDTH-1:0] user;
    logic [STRB_W-1:0]         strb;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic                      last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  beat_t            mem_q [DEPTH];
  beat_t            in_beat, head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d, bursts_q, bursts_d;
  state_e           state_q, state_d;
  logic             drop_done_q, drop_done_d;
  logic             empty, full, push, pop, pop_last;

  assign in_beat.user = s_axi4_wuser;
  assign in_beat.strb = s_axi4_wstrb;
  assign in_beat.data = s_axi4_wdata;
  assign in_beat.last = s_axi4_wlast;

  // head entry is read straight from storage; it only moves on a pop,
  // which keeps the payload stable while m_axi4_wvalid waits for ready
  assign head     = mem_q[rd_ptr_q];
  assign empty    = (fill_q == '0);
  assign full     = (fill_q == CNT_W'(DEPTH));
  assign push     = s_axi4_wvalid && !full;
  assign pop_last = pop && head.last;

  assign s_axi4_wready = !full;
  assign m_axi4_wdata  = head.data;
  assign m_axi4_wstrb  = head.strb;
  assign m_axi4_wlast  = head.last;
  assign m_axi4_wuser  = head.user;
  assign drop_done     = drop_done_q;
  assign fill_level    = fill_q;
  assign bursts_stored = bursts_q;

  // storage write; contents deliberately survive reset
  always_ff @(posedge axi4_aclk) begin
    if (push) mem_q[wr_ptr_q] <= in_beat;
  end

  // pointer / counter next-state; pointers wrap at DEPTH (power of two)
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d      = fill_q + CNT_W'(push) - CNT_W'(pop);
    bursts_d    = bursts_q + CNT_W'(push && s_axi4_wlast) - CNT_W'(pop_last);
    drop_done_d = (state_q == DROP) && pop_last;
  end

  // state register plus FIFO bookkeeping, synchronous active-low reset
  always_ff @(posedge axi4_aclk) begin
    if (!axi4_arstn) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      bursts_q    <= '0;
      drop_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      bursts_q    <= bursts_d;
      drop_done_q <= drop_done_d;
    end
  end

  // next state: one command per burst, back to IDLE on the wlast pop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid) state_d = cmd_drop ? DROP : FWD;
      FWD,
      DROP:     if (pop_last)  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // outputs per state; DROP drains one beat per cycle without wvalid
  always_comb begin
    cmd_ready     = 1'b0;
    m_axi4_wvalid = 1'b0;
    pop           = 1'b0;
    case (state_q)
      IDLE: cmd_ready = 1'b1;
      FWD: begin
        m_axi4_wvalid = !empty;
        pop           = !empty && m_axi4_wready;
      end
      DROP: pop = !empty;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_w_buffer_drop.sv
// Bench for axi4_w_buffer_drop: directed steps plus a random phase, all
// checked every cycle against a queue-based model of the buffer.
module tb_axi4_w_buffer_drop;

  localparam int DW    = 32;
  localparam int UW    = 2;
  localparam int DEPTH = 4;
  localparam int SW    = DW/8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          arstn;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic          s_wlast;
  logic [UW-1:0] s_wuser;
  logic          s_wvalid;
  logic          s_wready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast;
  logic [UW-1:0] m_wuser;
  logic          m_wvalid;
  logic          m_wready;
  logic          cmd_valid, cmd_drop, cmd_ready, drop_done;
  logic [CW-1:0] fill_level, bursts_stored;

  always #5 clk = ~clk;

  axi4_w_buffer_drop #(.AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW), .DEPTH(DEPTH)) dut (
    .axi4_aclk(clk), .axi4_arstn(arstn),
    .s_axi4_wdata(s_wdata), .s_axi4_wstrb(s_wstrb), .s_axi4_wlast(s_wlast),
    .s_axi4_wuser(s_wuser), .s_axi4_wvalid(s_wvalid), .s_axi4_wready(s_wready),
    .m_axi4_wdata(m_wdata), .m_axi4_wstrb(m_wstrb), .m_axi4_wlast(m_wlast),
    .m_axi4_wuser(m_wuser), .m_axi4_wvalid(m_wvalid), .m_axi4_wready(m_wready),
    .cmd_valid(cmd_valid), .cmd_drop(cmd_drop), .cmd_ready(cmd_ready),
    .drop_done(drop_done), .fill_level(fill_level), .bursts_stored(bursts_stored)
  );

  typedef struct packed {
    logic [UW-1:0] u;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  // model: stored beats in order, command mode (0 idle, 1 forward, 2 drop)
  beat_t         q[$];
  int            mst;
  bit            mdd, mv;
  logic [DW-1:0] dlv[$];
  int            checks, errors;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one clock: check outputs at negedge, advance model at posedge
  task automatic tick();
    int    sz, nb, ost;
    bit    pop, plast, push, cv, cd;
    beat_t nbeat;
    @(negedge clk);
    if (mv && arstn) begin
      sz = q.size();
      nb = 0;
      foreach (q[i]) if (q[i].l) nb++;
      chk("s_wready", s_wready, sz != DEPTH);
      chk("cmd_ready", cmd_ready, mst == 0);
      chk("m_wvalid", m_wvalid, mst == 1 && sz > 0);
      chk("drop_done", drop_done, mdd);
      chk("fill_level", fill_level, sz);
      chk("bursts_stored", bursts_stored, nb);
      if (mst == 1 && sz > 0) begin
        chk("m_wdata", m_wdata, q[0].d);
        chk("m_wstrb", m_wstrb, q[0].s);
        chk("m_wuser", m_wuser, q[0].u);
        chk("m_wlast", m_wlast, q[0].l);
      end
      if (m_wvalid === 1'b1 && m_wready) dlv.push_back(m_wdata);
    end
    sz      = q.size();
    pop     = (mst == 1 && sz > 0 && m_wready) || (mst == 2 && sz > 0);
    plast   = pop && q[0].l;
    push    = s_wvalid && (sz != DEPTH);
    nbeat.u = s_wuser;
    nbeat.s = s_wstrb;
    nbeat.d = s_wdata;
    nbeat.l = s_wlast;
    cv      = cmd_valid;
    cd      = cmd_drop;
    ost     = mst;
    @(posedge clk);
    if (!arstn) begin
      q.delete();
      mst = 0;
      mdd = 0;
      mv  = 1;
    end else if (mv) begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(nbeat);
      mdd = (ost == 2) && plast;
      if (ost == 0 && cv) mst = cd ? 2 : 1;
      else if (plast)     mst = 0;
    end
    #1;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic l);
    s_wvalid = 1'b1;
    s_wdata  = d;
    s_wlast  = l;
    s_wstrb  = SW'($urandom);
    s_wuser  = UW'($urandom);
  endtask

  task automatic issue_cmd(input logic drop);
    cmd_valid = 1'b1;
    cmd_drop  = drop;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] exp_d[$];
    int idx, cyc, cmds;
    bit acc;
    checks = 0; errors = 0; mv = 0; mst = 0; mdd = 0;
    arstn = 1'b0; s_wvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0;
    s_wuser = '0; m_wready = 1'b0; cmd_valid = 1'b0; cmd_drop = 1'b0;

    // reset held for two cycles
    tick(); tick();
    arstn = 1'b1;
    chk("rst_wready", s_wready, 1);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_fill", fill_level, 0);
    chk("rst_bursts", bursts_stored, 0);
    chk("rst_drop_done", drop_done, 0);

    // forward a 4-beat burst whose data is already stored
    m_wready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_beat(DW'((i + 1) * 'h11), i == 3);
      tick();
    end
    s_wvalid = 1'b0;
    chk("fwd_bursts", bursts_stored, 1);
    issue_cmd(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("fwd_valid", m_wvalid, 1);
      chk("fwd_data", m_wdata, (i + 1) * 'h11);
      chk("fwd_last", m_wlast, i == 3);
      tick();
    end
    chk("fwd_cmd_ready_after", cmd_ready, 1);

    // drop a 3-beat burst
    for (int i = 0; i < 3; i++) begin
      drive_beat(DW'('hA1 + i), i == 2);
      tick();
    end
    s_wvalid = 1'b0;
    chk("drop_bursts_pre", bursts_stored, 1);
    issue_cmd(1'b1);
    for (int k = 3; k >= 1; k--) begin
      chk("drop_fill", fill_level, k);
      chk("drop_wvalid", m_wvalid, 0);
      chk("drop_done_early", drop_done, 0);
      tick();
    end
    chk("drop_fill_end", fill_level, 0);
    chk("drop_done_pulse", drop_done, 1);
    chk("drop_bursts_post", bursts_stored, 0);
    tick();
    chk("drop_done_clear", drop_done, 0);
    chk("drop_cmd_ready", cmd_ready, 1);

    // full + backpressure: 6-beat burst, ready held low for a while
    m_wready = 1'b0;
    dlv.delete();
    exp_d.delete();
    issue_cmd(1'b0);
    idx = 0; cyc = 0;
    while (idx < 6 && cyc < 60) begin
      drive_beat(DW'('hB1 + idx), idx == 5);
      if (cyc == 6) begin
        chk("full_fill", fill_level, DEPTH);
        chk("full_wready", s_wready, 0);
      end
      if (cyc == 8) m_wready = 1'b1;
      acc = s_wready;
      tick();
      if (acc) begin
        exp_d.push_back(DW'('hB1 + idx));
        idx++;
      end
      cyc++;
    end
    s_wvalid = 1'b0;
    chk("bp_push_done", idx, 6);
    while (dlv.size() < 6 && cyc < 100) begin tick(); cyc++; end
    chk("bp_count", dlv.size(), 6);
    foreach (exp_d[i]) if (i < dlv.size()) chk("bp_order", dlv[i], exp_d[i]);

    // 10 single-beat bursts at full rate, pointers wrap
    dlv.delete();
    m_wready = 1'b1;
    idx = 0; cmds = 0; cyc = 0;
    cmd_valid = 1'b1; cmd_drop = 1'b0;
    while ((idx < 10 || dlv.size() < 10) && cyc < 200) begin
      if (idx < 10) drive_beat(DW'('hC0 + idx), 1'b1);
      else s_wvalid = 1'b0;
      cmd_valid = (cmds < 10);
      acc = s_wready && s_wvalid;
      if (cmd_valid && cmd_ready) cmds++;
      tick();
      if (acc) idx++;
      cyc++;
    end
    cmd_valid = 1'b0; s_wvalid = 1'b0;
    chk("stream_count", dlv.size(), 10);
    for (int i = 0; i < 10; i++) if (i < dlv.size()) chk("stream_order", dlv[i], 'hC0 + i);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      s_wvalid  = ($urandom_range(0, 3) != 0);
      s_wdata   = $urandom;
      s_wstrb   = SW'($urandom);
      s_wuser   = UW'($urandom);
      s_wlast   = ($urandom_range(0, 3) == 0);
      m_wready  = ($urandom_range(0, 2) != 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_drop  = ($urandom_range(0, 2) == 0);
      tick();
    end
    s_wvalid = 1'b0; cmd_valid = 1'b0;

    // reset in the middle of a forwarded burst
    arstn = 1'b0; tick(); arstn = 1'b1;
    m_wready = 1'b0;
    issue_cmd(1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_beat(DW'('hD1 + i), 1'b0);
      tick();
    end
    s_wvalid = 1'b0;
    chk("mid_fill_pre", fill_level, 2);
    arstn = 1'b0; tick(); arstn = 1'b1;
    chk("mid_fill_rst", fill_level, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_wvalid", m_wvalid, 0);
    chk("mid_bursts", bursts_stored, 0);
    dlv.delete();
    m_wready = 1'b1;
    issue_cmd(1'b0);
    for (int i = 0; i < 2; i++) begin
      drive_beat(DW'('hE1 + i), i == 1);
      tick();
    end
    s_wvalid = 1'b0;
    cyc = 0;
    while (dlv.size() < 2 && cyc < 10) begin tick(); cyc++; end
    chk("mid_count", dlv.size(), 2);
    for (int i = 0; i < 2; i++) if (i < dlv.size()) chk("mid_data", dlv[i], 'hE1 + i);
    tick();
    chk("mid_cmd_ready_end", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
